// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents:
//   state_e  - controller state (run, multi-cycle load-use stall, multi-cycle flush)
//   NopInstr - instruction word the IF/ID register takes when flushed
package pipeline_hazard_pkg;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StFlush     = 2'd2
  } state_e;

  localparam logic [31:0] NopInstr = 32'h0000_0000;

endpackage

// File: rtl/hazard_compare.sv
// Load-use hazard detector for the instruction sitting in ID.
// Ports:
//   id_rs_i, id_rt_i  - source register specifiers of the ID instruction
//   id_uses_rt_i      - ID instruction actually reads rt
//   ex_rt_i           - destination rt of the instruction in EX
//   ex_mem_read_i     - EX instruction is a load
//   hz_o              - ID must wait for the load result
module hazard_compare #(
  parameter int unsigned RegAddrW = 5
) (
  input  logic [RegAddrW-1:0] id_rs_i,
  input  logic [RegAddrW-1:0] id_rt_i,
  input  logic                id_uses_rt_i,
  input  logic [RegAddrW-1:0] ex_rt_i,
  input  logic                ex_mem_read_i,
  output logic                hz_o
);

  logic rs_match;
  logic rt_match;
  logic dst_nonzero;

  always_comb begin
    rs_match    = (ex_rt_i == id_rs_i);
    rt_match    = id_uses_rt_i && (ex_rt_i == id_rt_i);
    // $zero is hard-wired, so a load into it never produces a value to wait for
    dst_nonzero = (ex_rt_i != '0);
    hz_o        = ex_mem_read_i && dst_nonzero && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller beside the ID stage of the 5-stage MIPS pipeline.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   idRs, idRt, idUsesRt - operands of the ID instruction
//   exRt, exMemRead     - destination and load flag of the EX instruction
//   branchTaken         - branch/jump resolved taken this cycle
//   memBusy             - memory not ready; freezes the whole pipe
//   pcWrite, ifIdWrite  - PC and IF/ID load enables
//   ifIdFlush           - IF/ID loads a NOP on the next edge
//   idExBubble          - ID/EX control signals zeroed
//   pipeFreeze          - hold ID/EX, EX/MEM, MEM/WB
//   stallCount, flushCount - saturating load-use stall / flush cycle counters
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W          = 5,
  parameter int unsigned LOAD_USE_CYCLES     = 1,
  parameter int unsigned BRANCH_FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRt,
  input  logic [REG_ADDR_W-1:0] exRt,
  input  logic                  exMemRead,
  input  logic                  branchTaken,
  input  logic                  memBusy,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  ifIdFlush,
  output logic                  idExBubble,
  output logic                  pipeFreeze,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
);

  localparam int unsigned MaxCycles =
      (LOAD_USE_CYCLES > BRANCH_FLUSH_CYCLES) ? LOAD_USE_CYCLES : BRANCH_FLUSH_CYCLES;
  localparam int unsigned CntStateW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  // The first cycle of a stall/flush is spent in StRun, so the extra-cycle
  // counter is loaded with length-2 and the last cycle is the one at zero.
  localparam logic [CntStateW-1:0] StallReload =
      CntStateW'((LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0);
  localparam logic [CntStateW-1:0] FlushReload =
      CntStateW'((BRANCH_FLUSH_CYCLES > 1) ? BRANCH_FLUSH_CYCLES - 2 : 0);

  state_e                state_q, state_d;
  logic [CntStateW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic                  stall_inc;
  logic                  flush_inc;
  logic                  hz;

  hazard_compare #(
    .RegAddrW(REG_ADDR_W)
  ) u_hazard_compare (
    .id_rs_i      (idRs),
    .id_rt_i      (idRt),
    .id_uses_rt_i (idUsesRt),
    .ex_rt_i      (exRt),
    .ex_mem_read_i(exMemRead),
    .hz_o         (hz)
  );

  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    pipeFreeze = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end else if (memBusy) begin
      // Whole pipe holds; nothing advances, so no state or counter moves either
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      pipeFreeze = 1'b1;
    end else begin
      case (state_q)
        StRun, StLoadStall: begin
          if (branchTaken) begin
            // ID instruction is squashed, so any pending load-use wait is moot
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            flush_inc  = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
              state_d = StFlush;
              cnt_d   = FlushReload;
            end else begin
              state_d = StRun;
            end
          end else if (state_q == StLoadStall) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            stall_inc  = 1'b1;
            if (cnt_q == '0) begin
              state_d = StRun;
            end else begin
              cnt_d = cnt_q - CntStateW'(1);
            end
          end else if (hz) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            stall_inc  = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = StLoadStall;
              cnt_d   = StallReload;
            end
          end
        end
        StFlush: begin
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
          flush_inc  = 1'b1;
          if (cnt_q == '0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - CntStateW'(1);
          end
        end
        default: begin
          // Illegal encoding: behave as an idle run cycle and recover
          state_d = StRun;
        end
      endcase
    end

    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances share stimulus, one with default
// parameters and one with LOAD_USE_CYCLES=3, BRANCH_FLUSH_CYCLES=2, CNT_W=4.
// A remaining-cycles model is checked against both every negative edge, and
// directed literal checks pin the scenarios.
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] idRs = '0, idRt = '0, exRt = '0;
  logic       idUsesRt = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0, memBusy = 1'b0;

  logic        a_pcWrite, a_ifIdWrite, a_ifIdFlush, a_idExBubble, a_pipeFreeze;
  logic [15:0] a_stallCount, a_flushCount;
  logic        b_pcWrite, b_ifIdWrite, b_ifIdFlush, b_idExBubble, b_pipeFreeze;
  logic [3:0]  b_stallCount, b_flushCount;

  int nvec  = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .LOAD_USE_CYCLES(1), .BRANCH_FLUSH_CYCLES(1), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exRt(exRt), .exMemRead(exMemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .pcWrite(a_pcWrite), .ifIdWrite(a_ifIdWrite), .ifIdFlush(a_ifIdFlush),
    .idExBubble(a_idExBubble), .pipeFreeze(a_pipeFreeze),
    .stallCount(a_stallCount), .flushCount(a_flushCount)
  );

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .LOAD_USE_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)
  ) dut_b (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exRt(exRt), .exMemRead(exMemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .pcWrite(b_pcWrite), .ifIdWrite(b_ifIdWrite), .ifIdFlush(b_ifIdFlush),
    .idExBubble(b_idExBubble), .pipeFreeze(b_pipeFreeze),
    .stallCount(b_stallCount), .flushCount(b_flushCount)
  );

  // Output patterns {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze}
  localparam logic [4:0] ONrm = 5'b11000;
  localparam logic [4:0] OStl = 5'b00010;
  localparam logic [4:0] OFls = 5'b11110;
  localparam logic [4:0] OFrz = 5'b00001;
  localparam logic [4:0] ORst = 5'b00010;

  int p_len_stall[2] = '{1, 3};
  int p_len_flush[2] = '{1, 2};
  int p_cnt_max[2]   = '{65535, 15};
  int m_stall_left[2] = '{0, 0};
  int m_flush_left[2] = '{0, 0};
  int m_sc[2] = '{0, 0};
  int m_fc[2] = '{0, 0};

  logic [4:0] exp_o, act_o;
  int         act_sc, act_fc;
  logic       m_hz;

  // Model: counts of stall/flush cycles still owed; a flush in progress beats
  // everything, a new branch beats a pending or new load-use stall.
  initial begin
    forever begin
      @(negedge clock);
      m_hz = exMemRead && (exRt != 0) && (exRt == idRs || (idUsesRt && exRt == idRt));
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          act_o  = {a_pcWrite, a_ifIdWrite, a_ifIdFlush, a_idExBubble, a_pipeFreeze};
          act_sc = int'(a_stallCount);
          act_fc = int'(a_flushCount);
        end else begin
          act_o  = {b_pcWrite, b_ifIdWrite, b_ifIdFlush, b_idExBubble, b_pipeFreeze};
          act_sc = int'(b_stallCount);
          act_fc = int'(b_flushCount);
        end
        if (reset) begin
          m_stall_left[i] = 0;
          m_flush_left[i] = 0;
          m_sc[i] = 0;
          m_fc[i] = 0;
        end
        // counters as they stand this cycle, before this cycle's update
        nvec++;
        if (act_sc != m_sc[i] || act_fc != m_fc[i]) begin
          nfail++;
          $display("FAIL counters inst%0d t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   i, $time, act_sc, act_fc, m_sc[i], m_fc[i]);
        end
        if (reset) begin
          exp_o = ORst;
        end else if (memBusy) begin
          exp_o = OFrz;
        end else if (m_flush_left[i] > 0) begin
          exp_o = OFls;
          m_flush_left[i]--;
          if (m_fc[i] < p_cnt_max[i]) m_fc[i]++;
        end else if (branchTaken) begin
          exp_o = OFls;
          m_flush_left[i] = p_len_flush[i] - 1;
          m_stall_left[i] = 0;
          if (m_fc[i] < p_cnt_max[i]) m_fc[i]++;
        end else if (m_stall_left[i] > 0) begin
          exp_o = OStl;
          m_stall_left[i]--;
          if (m_sc[i] < p_cnt_max[i]) m_sc[i]++;
        end else if (m_hz) begin
          exp_o = OStl;
          m_stall_left[i] = p_len_stall[i] - 1;
          if (m_sc[i] < p_cnt_max[i]) m_sc[i]++;
        end else begin
          exp_o = ONrm;
        end
        nvec++;
        if (act_o !== exp_o) begin
          nfail++;
          $display("FAIL outputs inst%0d t=%0t got %b want %b", i, $time, act_o, exp_o);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] ert, input logic mr, input logic br,
                       input logic mb);
    idRs = rs; idRt = rt; idUsesRt = urt; exRt = ert;
    exMemRead = mr; branchTaken = br; memBusy = mb;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    idle();
    #2;
    chk("rst pcWrite", int'(a_pcWrite), 0);
    chk("rst idExBubble", int'(a_idExBubble), 1);
    chk("rst pipeFreeze", int'(b_pipeFreeze), 0);
    do_reset();

    // Single load-use hazard on rs
    drive(5'd8, 5'd3, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("lu A pcWrite", int'(a_pcWrite), 0);
    chk("lu A idExBubble", int'(a_idExBubble), 1);
    step();
    chk("lu A stallCount", int'(a_stallCount), 1);
    idle();
    #1;
    chk("lu A resumes", int'(a_pcWrite), 1);
    chk("lu B still stalled", int'(b_pcWrite), 0);
    step();
    step();
    chk("lu B stallCount", int'(b_stallCount), 3);
    chk("lu B resumes", int'(b_pcWrite), 1);
    step();

    // Register zero and rt qualifier
    do_reset();
    drive(5'd0, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("zero reg no stall", int'(a_pcWrite), 1);
    step();
    drive(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rt unused no stall", int'(a_pcWrite), 1);
    step();
    drive(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rt used stall", int'(a_pcWrite), 0);
    step();
    idle();
    step();
    chk("rt A stallCount", int'(a_stallCount), 1);

    // memBusy inside the 3-cycle stall
    do_reset();
    drive(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    step();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("busy B pipeFreeze", int'(b_pipeFreeze), 1);
    chk("busy B pcWrite", int'(b_pcWrite), 0);
    step();
    idle();
    step();
    step();
    chk("busy B stallCount", int'(b_stallCount), 3);
    chk("busy B resumes", int'(b_pcWrite), 1);
    chk("busy A stallCount", int'(a_stallCount), 1);
    step();

    // Branch with simultaneous hazard
    do_reset();
    drive(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    #1;
    chk("br B ifIdFlush c1", int'(b_ifIdFlush), 1);
    step();
    idle();
    #1;
    chk("br B ifIdFlush c2", int'(b_ifIdFlush), 1);
    chk("br B pcWrite c2", int'(b_pcWrite), 1);
    step();
    chk("br B flushCount", int'(b_flushCount), 2);
    chk("br B stallCount", int'(b_stallCount), 0);
    chk("br A flushCount", int'(a_flushCount), 1);
    chk("br B no flush c3", int'(b_ifIdFlush), 0);
    step();

    // Asynchronous reset in the middle of a multi-cycle stall
    do_reset();
    drive(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    #1;
    chk("ar B in stall", int'(b_pcWrite), 0);
    chk("ar B count before", int'(b_stallCount), 1);
    reset = 1'b1;
    #1;
    chk("ar B pcWrite", int'(b_pcWrite), 0);
    chk("ar B idExBubble", int'(b_idExBubble), 1);
    chk("ar B ifIdWrite", int'(b_ifIdWrite), 0);
    chk("ar B stallCount", int'(b_stallCount), 0);
    step();
    reset = 1'b0;
    #1;
    chk("ar B first clean pcWrite", int'(b_pcWrite), 1);
    step();
    chk("ar B stays run", int'(b_pcWrite), 1);

    // Saturation with a held hazard
    do_reset();
    drive(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat B stallCount", int'(b_stallCount), 15);
    chk("sat A stallCount", int'(a_stallCount), 20);
    idle();
    repeat (3) step();

    // Mixed directed sequence, checked by the model
    for (int i = 0; i < 60; i++) begin
      drive(5'(7 + i % 4), 5'(7 + (i * 3) % 5), 1'(i % 2), 5'd8, 1'(i % 3 != 0),
            1'(i % 7 == 3), 1'(i % 11 == 5));
      step();
    end
    idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
